// File: rtl/ds_pkg.sv
// Shared types and defaults for the 2x2 downsampling address generator.
package ds_pkg;

  localparam int ADDR_W_DEF = 20;
  localparam int IMG_W_DEF  = 256;
  localparam int IMG_H_DEF  = 256;
  localparam int HALF_W     = IMG_W_DEF / 2;
  localparam int HALF_H     = IMG_H_DEF / 2;

  typedef enum logic [2:0] {
    IDLE,
    S00,
    S01,
    S10,
    S11,
    DST,
    DONE
  } ds_state_e;

  // Counter width that stays at least one bit for a single-entry range.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ds_pixel_counter.sv
// Output-pixel row/column counter with column-wrap and last-pixel flags.
// Latency: flags reflect the registered position; advances on the same edge as adv_i.
// Backpressure: none; advances only when the caller pulses adv_i.
module ds_pixel_counter
  import ds_pkg::*;
#(
  parameter int COLS = HALF_W,
  parameter int ROWS = HALF_H
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic adv_i,
  output logic col_wrap_o,
  output logic last_o
);

  localparam int CW = cnt_w(COLS);
  localparam int RW = cnt_w(ROWS);

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;

  assign col_wrap_o = (col_q == CW'(COLS - 1));
  assign last_o     = col_wrap_o && (row_q == RW'(ROWS - 1));

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (clr_i) begin
      col_d = '0;
      row_d = '0;
    end else if (adv_i) begin
      if (col_wrap_o) begin
        col_d = '0;
        row_d = last_o ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

endmodule

// File: rtl/ds_addr_gen.sv
// 2x2 downsampling address generator: four source addresses then one destination per pixel.
// Latency: start/step edge registers the next address; addr_we pulses for its first cycle.
// Backpressure: step=0 holds the current address indefinitely with addr_we low.
module ds_addr_gen
  import ds_pkg::*;
#(
  parameter int IMG_W  = IMG_W_DEF,
  parameter int IMG_H  = IMG_H_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              step,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  output logic [ADDR_W-1:0] addr_out,
  output logic              addr_we,
  output logic              addr_sel,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] ROW_OFS  = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(2 * IMG_W);

  ds_state_e         state_q, state_d;
  logic [ADDR_W-1:0] row_ptr_q, row_ptr_d;
  logic [ADDR_W-1:0] col_off_q, col_off_d;
  logic [ADDR_W-1:0] dst_ptr_q, dst_ptr_d;
  logic              we_q, we_d;
  logic              frame_start, pix_adv, col_wrap, last_pix;

  assign frame_start = (state_q == IDLE) && start;
  assign pix_adv     = (state_q == DST) && step;

  ds_pixel_counter #(
    .COLS(IMG_W / 2),
    .ROWS(IMG_H / 2)
  ) u_pix_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (frame_start),
    .adv_i     (pix_adv),
    .col_wrap_o(col_wrap),
    .last_o    (last_pix)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      row_ptr_q <= '0;
      col_off_q <= '0;
      dst_ptr_q <= '0;
      we_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_ptr_q <= row_ptr_d;
      col_off_q <= col_off_d;
      dst_ptr_q <= dst_ptr_d;
      we_q      <= we_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = S00;
      S00:     if (step)  state_d = S01;
      S01:     if (step)  state_d = S10;
      S10:     if (step)  state_d = S11;
      S11:     if (step)  state_d = DST;
      DST:     if (step)  state_d = last_pix ? DONE : S00;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Running adders replace r*2*IMG_W, 2c and r*IMG_W/2+c.
  always_comb begin
    row_ptr_d = row_ptr_q;
    col_off_d = col_off_q;
    dst_ptr_d = dst_ptr_q;
    if (frame_start) begin
      row_ptr_d = src_base;
      col_off_d = '0;
      dst_ptr_d = dst_base;
    end else if (pix_adv) begin
      dst_ptr_d = dst_ptr_q + 1'b1;
      if (col_wrap) begin
        col_off_d = '0;
        row_ptr_d = row_ptr_q + ROW_STEP;
      end else begin
        col_off_d = col_off_q + ADDR_W'(2);
      end
    end
  end

  // Write pulse marks the first cycle of every emit state.
  assign we_d = (state_d != state_q) && (state_d != IDLE) && (state_d != DONE);

  always_comb begin
    addr_out = '0;
    addr_sel = 1'b0;
    unique case (state_q)
      S00:     addr_out = row_ptr_q + col_off_q;
      S01:     addr_out = row_ptr_q + col_off_q + 1'b1;
      S10:     addr_out = row_ptr_q + ROW_OFS + col_off_q;
      S11:     addr_out = row_ptr_q + ROW_OFS + col_off_q + 1'b1;
      DST: begin
        addr_out = dst_ptr_q;
        addr_sel = 1'b1;
      end
      default: ;
    endcase
  end

  assign addr_we = we_q;
  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);

endmodule

// File: tb/tb_ds_addr_gen.sv
// Randomized bench for ds_addr_gen (4x4 image) against a per-frame address-list model.
module tb_ds_addr_gen;

  localparam int W = 4;
  localparam int H = 4;
  localparam int NADDR = (W / 2) * (H / 2) * 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        step = 1'b0;
  logic [19:0] src_base = '0;
  logic [19:0] dst_base = '0;
  logic [19:0] addr_out;
  logic        addr_we, addr_sel, busy, done;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: 0 idle, 1 emitting m_list[m_pos], 2 done cycle.
  int          m_st = 0;
  int          m_pos = 0;
  logic        m_we = 1'b0;
  logic [19:0] m_list[$];
  logic [19:0] cap[$];
  int          done_cnt = 0;

  logic [19:0] basic_exp[NADDR] = '{
    20'h00100, 20'h00101, 20'h00104, 20'h00105, 20'h00800,
    20'h00102, 20'h00103, 20'h00106, 20'h00107, 20'h00801,
    20'h00108, 20'h00109, 20'h0010C, 20'h0010D, 20'h00802,
    20'h0010A, 20'h0010B, 20'h0010E, 20'h0010F, 20'h00803};
  logic [19:0] wrap_exp[4] = '{20'hFFFFE, 20'hFFFFF, 20'h00002, 20'h00003};

  ds_addr_gen #(.IMG_W(W), .IMG_H(H), .ADDR_W(20)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .step    (step),
    .src_base(src_base),
    .dst_base(dst_base),
    .addr_out(addr_out),
    .addr_we (addr_we),
    .addr_sel(addr_sel),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic build(input logic [19:0] s, input logic [19:0] d);
    int unsigned b;
    m_list.delete();
    for (int r = 0; r < H / 2; r++) begin
      for (int c = 0; c < W / 2; c++) begin
        b = s + r * 2 * W + 2 * c;
        m_list.push_back(20'(b));
        m_list.push_back(20'(b + 1));
        m_list.push_back(20'(b + W));
        m_list.push_back(20'(b + W + 1));
        m_list.push_back(20'(d + r * (W / 2) + c));
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    case (m_st)
      0: begin
        m_we = start;
        if (start) begin
          build(src_base, dst_base);
          m_pos = 0;
          m_st  = 1;
        end
      end
      1: begin
        m_we = step;
        if (step) begin
          m_pos++;
          if (m_pos == NADDR) begin
            m_st = 2;
            m_we = 1'b0;
          end
        end
      end
      default: begin
        m_st = 0;
        m_we = 1'b0;
      end
    endcase
    #1;
    chk("addr_we", addr_we, m_we);
    chk("busy", busy, m_st != 0);
    chk("done", done, m_st == 2);
    if (m_st == 1) begin
      chk("addr_out", addr_out, m_list[m_pos]);
      chk("addr_sel", addr_sel, (m_pos % 5) == 4);
    end
    if (addr_we) cap.push_back(addr_out);
    if (done) done_cnt++;
  endtask

  task automatic cycle(input logic st, input logic sp);
    start = st;
    step  = sp;
    tick();
  endtask

  // mode 0: step every cycle; 1: scripted stalls; 2: random step/start/base noise.
  task automatic run_frame(input int mode, input logic [19:0] src, input logic [19:0] dst,
                           input int stop_pos);
    int   n;
    int   stall;
    logic sp;
    logic st;
    cap.delete();
    done_cnt = 0;
    n = 0;
    stall = 0;
    src_base = src;
    dst_base = dst;
    cycle(1'b1, 1'b1);
    while (m_st != 0 && n < 1000) begin
      if (stop_pos >= 0 && m_st == 1 && m_pos == stop_pos) break;
      st = 1'b0;
      sp = 1'b1;
      case (mode)
        1: begin
          if (n < 2) sp = 1'b0;
          else if (m_pos == 2 && stall < 5) begin
            sp = 1'b0;
            stall++;
          end
        end
        2: begin
          sp = ($urandom_range(0, 3) != 0);
          st = 1'($urandom_range(0, 1));
          if ($urandom_range(0, 3) == 0) begin
            src_base = 20'($urandom);
            dst_base = 20'($urandom);
          end
        end
        default: ;
      endcase
      cycle(st, sp);
      n++;
    end
    start = 1'b0;
    step  = 1'b0;
    if (n >= 1000) chk("frame_timeout", n, 0);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #1;
    chk("rst_addr", addr_out, 0);
    chk("rst_we", addr_we, 0);
    chk("rst_sel", addr_sel, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    #10 rst_n = 1'b1;

    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1);

    run_frame(0, 20'h00100, 20'h00800, -1);
    chk("basic_cnt", cap.size(), NADDR);
    chk("basic_done_cnt", done_cnt, 1);
    for (int i = 0; i < NADDR; i++) chk("basic_seq", cap[i], basic_exp[i]);
    cycle(1'b0, 1'b0);

    run_frame(1, 20'h00100, 20'h00800, -1);
    chk("stall_cnt", cap.size(), NADDR);
    chk("stall_done_cnt", done_cnt, 1);

    run_frame(0, 20'hFFFFE, 20'h00800, -1);
    for (int i = 0; i < 4; i++) chk("wrap_seq", cap[i], wrap_exp[i]);

    for (int k = 0; k < 4; k++) begin
      run_frame(2, 20'($urandom), 20'($urandom), -1);
      chk("rand_cnt", cap.size(), NADDR);
      chk("rand_done_cnt", done_cnt, 1);
      cycle(1'b0, 1'b1);
    end

    // Reset while in S11 of the second pixel.
    run_frame(0, 20'h00100, 20'h00800, 8);
    chk("pre_rst_addr", addr_out, 20'h00107);
    #3 rst_n = 1'b0;
    #1;
    m_st = 0;
    m_we = 1'b0;
    chk("midrst_addr", addr_out, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_we", addr_we, 0);
    #2 rst_n = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1);
    chk("midrst_no_done", done_cnt, 0);
    run_frame(0, 20'h00100, 20'h00800, -1);
    chk("restart_first", cap[0], 20'h00100);
    chk("restart_cnt", cap.size(), NADDR);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
